// File: rtl/mc_control.sv
// Multicycle MIPS control unit: sequences FETCH/DECODE/EXEC/MEM/WB and handles
// prioritised interrupts and undefined-instruction exceptions.
module mc_control #(
    parameter int IRQ_N  = 1,
    parameter bit EXC_EN = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      Instruct,
    input  logic [IRQ_N-1:0] IRQ,
    input  logic             KernelMode,
    input  logic             MemReady,
    output logic             PCWr,
    output logic             PCWrCond,
    output logic             IRWr,
    output logic             IorD,
    output logic [2:0]       PCSrc,
    output logic [1:0]       RegDst,
    output logic             RegWr,
    output logic             ALUSrc1,
    output logic             ALUSrc2,
    output logic             Sign,
    output logic             MemWr,
    output logic             MemRd,
    output logic             EXTOp,
    output logic             LUOp,
    output logic [5:0]       ALUFun,
    output logic [1:0]       MemToReg,
    output logic [IRQ_N-1:0] IRQAck,
    output logic [2:0]       State
);
    localparam int SEL_W = (IRQ_N > 1) ? $clog2(IRQ_N) : 1;

    typedef enum logic [2:0] {
        S_FETCH = 3'd0, S_DECODE = 3'd1, S_EXEC = 3'd2, S_MEM = 3'd3,
        S_WB = 3'd4, S_IRQ = 3'd5, S_EXC = 3'd6, S_BAD = 3'd7
    } state_t;

    state_t state_q, state_d;
    logic [SEL_W-1:0] irq_sel_q, irq_sel_d, irq_low;

    logic [5:0] op, fn;
    logic is_r, legal, is_j, is_jal, is_jr, is_jalr, is_br, is_lw, is_sw;
    logic [5:0] alu_fun;
    logic alu_src1, alu_src2, sign_v, ext_op, lu_op;

    assign op      = Instruct[31:26];
    assign fn      = Instruct[5:0];
    assign is_r    = (op == 6'h00);
    assign is_j    = (op == 6'h02);
    assign is_jal  = (op == 6'h03);
    assign is_jr   = is_r && (fn == 6'h08);
    assign is_jalr = is_r && (fn == 6'h09);
    assign is_br   = (op == 6'h01) || (op >= 6'h04 && op <= 6'h07);
    assign is_lw   = (op == 6'h23);
    assign is_sw   = (op == 6'h2b);

    always_comb begin
        legal = 1'b0;
        if (is_r) begin
            case (fn)
                6'h00, 6'h02, 6'h03, 6'h08, 6'h09, 6'h2a, 6'h2b: legal = 1'b1;
                default: legal = (fn >= 6'h20 && fn <= 6'h27);
            endcase
        end else begin
            legal = (op <= 6'h0d) || (op == 6'h0f) || is_lw || is_sw;
        end
    end

    // ALU-side controls; only presented to the datapath during EXEC
    always_comb begin
        alu_fun  = 6'b000000;
        alu_src1 = 1'b0;
        alu_src2 = !is_r && !is_br;
        sign_v   = 1'b1;
        ext_op   = !(op == 6'h0c || op == 6'h0d);
        lu_op    = (op == 6'h0f);
        if (is_r) begin
            case (fn)
                6'h22, 6'h23: alu_fun = 6'b000001;
                6'h24:        alu_fun = 6'b011000;
                6'h25:        alu_fun = 6'b011110;
                6'h26:        alu_fun = 6'b010110;
                6'h27:        alu_fun = 6'b010001;
                6'h00:        alu_fun = 6'b100000;
                6'h02:        alu_fun = 6'b100001;
                6'h03:        alu_fun = 6'b100011;
                6'h2a, 6'h2b: alu_fun = 6'b110101;
                default:      alu_fun = 6'b000000;
            endcase
            alu_src1 = (fn == 6'h00 || fn == 6'h02 || fn == 6'h03);
            sign_v   = !(fn == 6'h21 || fn == 6'h23 || fn == 6'h2b);
        end else begin
            case (op)
                6'h0a, 6'h0b: alu_fun = 6'b110101;
                6'h0c:        alu_fun = 6'b011000;
                6'h0d:        alu_fun = 6'b011110;
                6'h04:        alu_fun = 6'b110011;
                6'h05:        alu_fun = 6'b110001;
                6'h06:        alu_fun = 6'b111101;
                6'h07:        alu_fun = 6'b111111;
                6'h01:        alu_fun = 6'b111011;
                default:      alu_fun = 6'b000000;
            endcase
            sign_v = !(op == 6'h09 || op == 6'h0b);
        end
    end

    // Lowest set index wins, so scan from the top down
    always_comb begin
        irq_low = '0;
        for (int i = IRQ_N - 1; i >= 0; i--) begin
            if (IRQ[i]) irq_low = SEL_W'(i);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_FETCH;
            irq_sel_q <= '0;
        end else begin
            state_q   <= state_d;
            irq_sel_q <= irq_sel_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        irq_sel_d = irq_sel_q;
        PCWr = 1'b0; PCWrCond = 1'b0; IRWr = 1'b0; IorD = 1'b0;
        PCSrc = 3'd0; RegDst = 2'd0; RegWr = 1'b0; MemToReg = 2'd0;
        ALUSrc1 = 1'b0; ALUSrc2 = 1'b0; Sign = 1'b0; EXTOp = 1'b0; LUOp = 1'b0;
        ALUFun = 6'd0; MemWr = 1'b0; MemRd = 1'b0; IRQAck = '0;
        case (state_q)
            S_FETCH: begin
                if ((|IRQ) && !KernelMode) begin
                    irq_sel_d = irq_low;
                    state_d   = S_IRQ;
                end else begin
                    MemRd = 1'b1;
                    if (MemReady) begin
                        IRWr    = 1'b1;
                        PCWr    = 1'b1;
                        state_d = S_DECODE;
                    end
                end
            end
            S_DECODE: begin
                if (!legal) begin
                    state_d = EXC_EN ? S_EXC : S_FETCH;
                end else if (is_j || is_jal) begin
                    PCWr     = 1'b1;
                    PCSrc    = 3'd2;
                    RegWr    = is_jal;
                    RegDst   = is_jal ? 2'd2 : 2'd0;
                    MemToReg = is_jal ? 2'd2 : 2'd0;
                    state_d  = S_FETCH;
                end else if (is_jr || is_jalr) begin
                    PCWr     = 1'b1;
                    PCSrc    = 3'd3;
                    RegWr    = is_jalr;
                    MemToReg = is_jalr ? 2'd2 : 2'd0;
                    state_d  = S_FETCH;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                ALUSrc1 = alu_src1; ALUSrc2 = alu_src2; ALUFun = alu_fun;
                Sign = sign_v; EXTOp = ext_op; LUOp = lu_op;
                if (is_br) begin
                    PCWrCond = 1'b1;
                    PCSrc    = 3'd1;
                    state_d  = S_FETCH;
                end else if (is_lw || is_sw) begin
                    state_d = S_MEM;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                IorD  = 1'b1;
                MemRd = is_lw;
                MemWr = is_sw;
                if (MemReady) state_d = is_lw ? S_WB : S_FETCH;
            end
            S_WB: begin
                RegWr    = 1'b1;
                RegDst   = is_r ? 2'd0 : 2'd1;
                MemToReg = is_lw ? 2'd1 : 2'd0;
                state_d  = S_FETCH;
            end
            S_IRQ: begin
                RegWr = 1'b1; RegDst = 2'd3; MemToReg = 2'd3;
                PCWr  = 1'b1; PCSrc = 3'd4;
                for (int i = 0; i < IRQ_N; i++) IRQAck[i] = (irq_sel_q == SEL_W'(i));
                state_d = S_FETCH;
            end
            S_EXC: begin
                RegWr = 1'b1; RegDst = 2'd3; MemToReg = 2'd2;
                PCWr  = 1'b1; PCSrc = 3'd5;
                state_d = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
        // Reset must kill strobes immediately, not at the next edge
        if (reset) begin
            PCWr = 1'b0; PCWrCond = 1'b0; IRWr = 1'b0; IorD = 1'b0;
            PCSrc = 3'd0; RegDst = 2'd0; RegWr = 1'b0; MemToReg = 2'd0;
            ALUSrc1 = 1'b0; ALUSrc2 = 1'b0; Sign = 1'b0; EXTOp = 1'b0; LUOp = 1'b0;
            ALUFun = 6'd0; MemWr = 1'b0; MemRd = 1'b0; IRQAck = '0;
        end
    end

    assign State = state_q;

endmodule

// File: tb/tb_mc_control.sv
// Directed vector bench for mc_control: per-cycle input/expected-output table plus
// hand sequences for asynchronous reset and the EXC_EN=0 variant.
module tb_mc_control;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, rst1, KernelMode, MemReady;
    logic [31:0] Instruct;
    logic [3:0]  irq;
    logic [0:0]  irq1;

    logic PCWr0, PCWrCond0, IRWr0, IorD0, RegWr0, ALUSrc10, ALUSrc20, Sign0, MemWr0, MemRd0, EXTOp0, LUOp0;
    logic [2:0] PCSrc0, State0;
    logic [1:0] RegDst0, MemToReg0;
    logic [5:0] ALUFun0;
    logic [3:0] IRQAck0;

    logic PCWr1, PCWrCond1, IRWr1, IorD1, RegWr1, ALUSrc11, ALUSrc21, Sign1, MemWr1, MemRd1, EXTOp1, LUOp1;
    logic [2:0] PCSrc1, State1;
    logic [1:0] RegDst1, MemToReg1;
    logic [5:0] ALUFun1;
    logic [0:0] IRQAck1;

    mc_control #(.IRQ_N(4), .EXC_EN(1'b1)) dut (
        .clk(clk), .reset(reset), .Instruct(Instruct), .IRQ(irq), .KernelMode(KernelMode),
        .MemReady(MemReady), .PCWr(PCWr0), .PCWrCond(PCWrCond0), .IRWr(IRWr0), .IorD(IorD0),
        .PCSrc(PCSrc0), .RegDst(RegDst0), .RegWr(RegWr0), .ALUSrc1(ALUSrc10), .ALUSrc2(ALUSrc20),
        .Sign(Sign0), .MemWr(MemWr0), .MemRd(MemRd0), .EXTOp(EXTOp0), .LUOp(LUOp0),
        .ALUFun(ALUFun0), .MemToReg(MemToReg0), .IRQAck(IRQAck0), .State(State0));

    mc_control #(.IRQ_N(1), .EXC_EN(1'b0)) dut_noexc (
        .clk(clk), .reset(rst1), .Instruct(Instruct), .IRQ(irq1), .KernelMode(KernelMode),
        .MemReady(MemReady), .PCWr(PCWr1), .PCWrCond(PCWrCond1), .IRWr(IRWr1), .IorD(IorD1),
        .PCSrc(PCSrc1), .RegDst(RegDst1), .RegWr(RegWr1), .ALUSrc1(ALUSrc11), .ALUSrc2(ALUSrc21),
        .Sign(Sign1), .MemWr(MemWr1), .MemRd(MemRd1), .EXTOp(EXTOp1), .LUOp(LUOp1),
        .ALUFun(ALUFun1), .MemToReg(MemToReg1), .IRQAck(IRQAck1), .State(State1));

    // {State, PCWr, PCWrCond, IRWr, IorD, RegWr, MemRd, MemWr, PCSrc, RegDst, MemToReg, ALUFun, IRQAck}
    logic [26:0] act0, act1;
    assign act0 = {State0, PCWr0, PCWrCond0, IRWr0, IorD0, RegWr0, MemRd0, MemWr0,
                   PCSrc0, RegDst0, MemToReg0, ALUFun0, IRQAck0};
    assign act1 = {State1, PCWr1, PCWrCond1, IRWr1, IorD1, RegWr1, MemRd1, MemWr1,
                   PCSrc1, RegDst1, MemToReg1, ALUFun1, 3'b000, IRQAck1};

    typedef struct {
        logic [31:0] ins;
        logic        mr;
        logic [3:0]  irq;
        logic        km;
        logic [26:0] exp;
    } vec_t;

    localparam logic [31:0] I_ADD = 32'h00221820, I_LW = 32'h8C430004, I_BGTZ = 32'h1C200003;
    localparam logic [31:0] I_JAL = 32'h0C000010, I_ILL = 32'hFC000000, I_SW = 32'hAC430004;
    // strobe field order: PCWr PCWrCond IRWr IorD RegWr MemRd MemWr
    localparam logic [6:0] F_RDY = 7'b1010010, F_WAIT = 7'b0000010, NONE = 7'b0000000;
    localparam logic [6:0] WBS = 7'b0000100, MEMR = 7'b0001010, MEMW = 7'b0001001;
    localparam logic [6:0] TRAP = 7'b1000100, BRS = 7'b0100000;

    int checks = 0;
    int failures = 0;
    vec_t v [24];

    function automatic logic [26:0] ex(input logic [2:0] st, input logic [6:0] ctl,
                                       input logic [2:0] pcsrc, input logic [1:0] rd,
                                       input logic [1:0] m2r, input logic [5:0] fun,
                                       input logic [3:0] ack);
        return {st, ctl, pcsrc, rd, m2r, fun, ack};
    endfunction

    function automatic vec_t mk(input logic [31:0] ins, input logic mr, input logic [3:0] rq,
                                input logic km, input logic [26:0] e);
        vec_t r;
        r.ins = ins; r.mr = mr; r.irq = rq; r.km = km; r.exp = e;
        return r;
    endfunction

    task automatic chk(input string name, input logic [26:0] a, input logic [26:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s actual=%b required=%b", name, a, e);
        end
    endtask

    initial begin
        v[0]  = mk(I_ADD, 1'b1, 4'b0, 1'b0, ex(3'd0, F_RDY, 3'd0, 2'd0, 2'd0, 6'd0, 4'd0));
        v[1]  = mk(I_ADD, 1'b1, 4'b0, 1'b0, ex(3'd1, NONE,  3'd0, 2'd0, 2'd0, 6'd0, 4'd0));
        v[2]  = mk(I_ADD, 1'b1, 4'b0, 1'b0, ex(3'd2, NONE,  3'd0, 2'd0, 2'd0, 6'b000000, 4'd0));
        v[3]  = mk(I_ADD, 1'b1, 4'b0, 1'b0, ex(3'd4, WBS,   3'd0, 2'd0, 2'd0, 6'd0, 4'd0));
        v[4]  = mk(I_LW,  1'b0, 4'b0, 1'b0, ex(3'd0, F_WAIT,3'd0, 2'd0, 2'd0, 6'd0, 4'd0));
        v[5]  = mk(I_LW,  1'b1, 4'b0, 1'b0, ex(3'd0, F_RDY, 3'd0, 2'd0, 2'd0, 6'd0, 4'd0));
        v[6]  = mk(I_LW,  1'b1, 4'b0, 1'b0, ex(3'd1, NONE,  3'd0, 2'd0, 2'd0, 6'd0, 4'd0));
        v[7]  = mk(I_LW,  1'b0, 4'b0, 1'b0, ex(3'd2, NONE,  3'd0, 2'd0, 2'd0, 6'd0, 4'd0));
        v[8]  = mk(I_LW,  1'b0, 4'b0, 1'b0, ex(3'd3, MEMR,  3'd0, 2'd0, 2'd0, 6'd0, 4'd0));
        v[9]  = mk(I_LW,  1'b0, 4'b0, 1'b0, ex(3'd3, MEMR,  3'd0, 2'd0, 2'd0, 6'd0, 4'd0));
        v[10] = mk(I_LW,  1'b0, 4'b0, 1'b0, ex(3'd3, MEMR,  3'd0, 2'd0, 2'd0, 6'd0, 4'd0));
        v[11] = mk(I_LW,  1'b1, 4'b0, 1'b0, ex(3'd3, MEMR,  3'd0, 2'd0, 2'd0, 6'd0, 4'd0));
        v[12] = mk(I_LW,  1'b1, 4'b0, 1'b0, ex(3'd4, WBS,   3'd0, 2'd1, 2'd1, 6'd0, 4'd0));
        v[13] = mk(I_LW,  1'b1, 4'b1010, 1'b0, ex(3'd0, NONE, 3'd0, 2'd0, 2'd0, 6'd0, 4'd0));
        v[14] = mk(I_LW,  1'b1, 4'b0000, 1'b0, ex(3'd5, TRAP, 3'd4, 2'd3, 2'd3, 6'd0, 4'b0010));
        v[15] = mk(I_BGTZ,1'b1, 4'b1010, 1'b1, ex(3'd0, F_RDY, 3'd0, 2'd0, 2'd0, 6'd0, 4'd0));
        v[16] = mk(I_BGTZ,1'b1, 4'b1010, 1'b1, ex(3'd1, NONE,  3'd0, 2'd0, 2'd0, 6'd0, 4'd0));
        v[17] = mk(I_BGTZ,1'b1, 4'b1010, 1'b1, ex(3'd2, BRS,   3'd1, 2'd0, 2'd0, 6'b111111, 4'd0));
        v[18] = mk(I_JAL, 1'b1, 4'b0, 1'b0, ex(3'd0, F_RDY, 3'd0, 2'd0, 2'd0, 6'd0, 4'd0));
        v[19] = mk(I_JAL, 1'b1, 4'b0, 1'b0, ex(3'd1, TRAP,  3'd2, 2'd2, 2'd2, 6'd0, 4'd0));
        v[20] = mk(I_ILL, 1'b1, 4'b0, 1'b0, ex(3'd0, F_RDY, 3'd0, 2'd0, 2'd0, 6'd0, 4'd0));
        v[21] = mk(I_ILL, 1'b1, 4'b0, 1'b0, ex(3'd1, NONE,  3'd0, 2'd0, 2'd0, 6'd0, 4'd0));
        v[22] = mk(I_ILL, 1'b1, 4'b0, 1'b0, ex(3'd6, TRAP,  3'd5, 2'd3, 2'd2, 6'd0, 4'd0));
        v[23] = mk(I_SW,  1'b1, 4'b0, 1'b0, ex(3'd0, F_RDY, 3'd0, 2'd0, 2'd0, 6'd0, 4'd0));

        reset = 1'b1; rst1 = 1'b1; Instruct = I_ADD; MemReady = 1'b1;
        irq = 4'b1010; irq1 = 1'b0; KernelMode = 1'b0;
        repeat (2) @(negedge clk);
        #1 chk("reset_hold", act0, ex(3'd0, NONE, 3'd0, 2'd0, 2'd0, 6'd0, 4'd0));
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 24; i++) begin
            Instruct = v[i].ins; MemReady = v[i].mr; irq = v[i].irq; KernelMode = v[i].km;
            #1 chk($sformatf("vec%0d", i), act0, v[i].exp);
            @(negedge clk);
        end

        // sw continues: DECODE, EXEC, then reset lands while MEM is stalled
        irq = 4'b0; KernelMode = 1'b0; MemReady = 1'b1;
        #1 chk("sw_decode", act0, ex(3'd1, NONE, 3'd0, 2'd0, 2'd0, 6'd0, 4'd0));
        @(negedge clk);
        #1 chk("sw_exec", act0, ex(3'd2, NONE, 3'd0, 2'd0, 2'd0, 6'd0, 4'd0));
        @(negedge clk);
        MemReady = 1'b0;
        #1 chk("sw_mem", act0, ex(3'd3, MEMW, 3'd0, 2'd0, 2'd0, 6'd0, 4'd0));
        #1 reset = 1'b1;
        #1 chk("sw_mem_reset", act0, ex(3'd0, NONE, 3'd0, 2'd0, 2'd0, 6'd0, 4'd0));
        @(negedge clk);
        reset = 1'b0;
        #1 chk("post_reset_fetch", act0, ex(3'd0, F_WAIT, 3'd0, 2'd0, 2'd0, 6'd0, 4'd0));

        // EXC_EN=0 instance: undefined opcode falls back to FETCH with no write-back
        @(negedge clk);
        rst1 = 1'b0; Instruct = I_ILL; MemReady = 1'b1;
        #1 chk("noexc_fetch", act1, ex(3'd0, F_RDY, 3'd0, 2'd0, 2'd0, 6'd0, 4'd0));
        @(negedge clk);
        #1 chk("noexc_decode", act1, ex(3'd1, NONE, 3'd0, 2'd0, 2'd0, 6'd0, 4'd0));
        @(negedge clk);
        MemReady = 1'b0;
        #1 chk("noexc_refetch", act1, ex(3'd0, F_WAIT, 3'd0, 2'd0, 2'd0, 6'd0, 4'd0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
